// File: rtl/adc_freq_pkg.sv
// Shared types and default parameters for the ADC front-end and its frequency counter.
package adc_freq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StMeas,
    StClose,
    StDiv
  } state_e;

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefDivW     = 16;
  localparam int unsigned DefCntW     = 24;
  localparam int unsigned DefMidpoint = 128;
  localparam int unsigned DefHyst     = 8;

endpackage

// File: rtl/serial_div.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses W edges after start is taken.
module serial_div #(
  parameter int unsigned W = 24
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [W-1:0] quotient_o
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [W:0]    shifted;
  logic [W:0]    diff;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (cnt_q != '0) begin
      // Borrow out of the trial subtraction means the partial remainder was too small.
      if (!diff[W]) begin
        rem_d = diff[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end else if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = CW'(W);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/adc_freq_front.sv
// ADC front-end: programmable sample clock, sample capture, Schmitt crossing detect and
// reciprocal period measurement over a programmable gate with timeout reporting.
module adc_freq_front
  import adc_freq_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned DIV_W    = DefDivW,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned MIDPOINT = DefMidpoint,
  parameter int unsigned HYST     = DefHyst
) (
  input  logic              clk_100MHz,
  input  logic              Rst,
  input  logic [DIV_W-1:0]  Div,
  input  logic [CNT_W-1:0]  Gate_Cycles,
  input  logic [DATA_W-1:0] ADC_Data,
  output logic              clk_ADC,
  output logic              ADC_En,
  output logic [DATA_W-1:0] Sample,
  output logic              Sample_Valid,
  output logic [CNT_W-1:0]  Period,
  output logic              Period_Valid,
  output logic              Timeout
);

  localparam logic [CNT_W-1:0]  CntMax = '1;
  localparam logic [DATA_W-1:0] HiThr  = DATA_W'(MIDPOINT + HYST);
  localparam logic [DATA_W-1:0] LoThr  = DATA_W'(MIDPOINT - HYST);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d, div_len_q, div_len_d, div_sat;
  logic              clk_adc_q, clk_adc_d, tc;
  logic              adc_en_q;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              schmitt_q, schmitt_d, xr_q, xr_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  t_q, t_d, n_q, n_d, g_q, g_d, w_q, w_d;
  logic [CNT_W-1:0]  period_q, period_d, div_quo;
  logic              period_valid_q, period_valid_d, timeout_q, timeout_d;
  logic              div_start, div_done;

  assign div_sat = (Div == '0) ? DIV_W'(1) : Div;

  // Sample clock, capture and Schmitt trigger.
  always_comb begin
    tc             = (div_cnt_q == div_len_q - DIV_W'(1));
    div_cnt_d      = tc ? '0 : div_cnt_q + DIV_W'(1);
    div_len_d      = tc ? div_sat : div_len_q;
    clk_adc_d      = clk_adc_q ^ tc;
    sample_valid_d = tc & clk_adc_q;
    sample_d       = sample_valid_d ? ADC_Data : sample_q;
    schmitt_d      = schmitt_q;
    xr_d           = 1'b0;
    if (sample_valid_q) begin
      if (!schmitt_q && (sample_q >= HiThr)) begin
        schmitt_d = 1'b1;
        xr_d      = 1'b1;
      end else if (schmitt_q && (sample_q <= LoThr)) begin
        schmitt_d = 1'b0;
      end
    end
  end

  // Measurement FSM.
  always_comb begin
    state_d        = state_q;
    t_d            = t_q;
    n_d            = n_q;
    g_d            = g_q;
    w_d            = '0;
    period_d       = period_q;
    period_valid_d = 1'b0;
    timeout_d      = timeout_q;
    div_start      = 1'b0;
    unique case (state_q)
      StIdle: state_d = StArm;
      StArm: begin
        if (xr_q) begin
          t_d     = '0;
          n_d     = '0;
          g_d     = Gate_Cycles;
          state_d = StMeas;
        end else if (w_q == CntMax - 1'b1) begin
          timeout_d = 1'b1;
        end else begin
          w_d = w_q + 1'b1;
        end
      end
      StMeas: begin
        t_d = t_q + 1'b1;
        if (t_q == CntMax - 1'b1) begin
          timeout_d = 1'b1;
          state_d   = StArm;
        end else begin
          if (xr_q) n_d = n_q + 1'b1;
          if (t_q >= g_q) state_d = StClose;
        end
      end
      StClose: begin
        t_d = t_q + 1'b1;
        if (t_q == CntMax - 1'b1) begin
          timeout_d = 1'b1;
          state_d   = StArm;
        end else if (xr_q) begin
          // Divider loads t_d/n_d on the DIV-entry edge.
          n_d       = n_q + 1'b1;
          div_start = 1'b1;
          state_d   = StDiv;
        end
      end
      StDiv: begin
        if (div_done) begin
          period_d       = div_quo;
          period_valid_d = 1'b1;
          timeout_d      = 1'b0;
          state_d        = StArm;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (!Rst) begin
      div_cnt_q      <= '0;
      div_len_q      <= div_sat;
      clk_adc_q      <= 1'b0;
      adc_en_q       <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      schmitt_q      <= 1'b0;
      xr_q           <= 1'b0;
      state_q        <= StIdle;
      t_q            <= '0;
      n_q            <= '0;
      g_q            <= '0;
      w_q            <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      div_len_q      <= div_len_d;
      clk_adc_q      <= clk_adc_d;
      adc_en_q       <= 1'b1;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      schmitt_q      <= schmitt_d;
      xr_q           <= xr_d;
      state_q        <= state_d;
      t_q            <= t_d;
      n_q            <= n_d;
      g_q            <= g_d;
      w_q            <= w_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  serial_div #(
    .W(CNT_W)
  ) u_div (
    .clk_i      (clk_100MHz),
    .rst_ni     (Rst),
    .start_i    (div_start),
    .dividend_i (t_d),
    .divisor_i  (n_d),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  assign clk_ADC      = clk_adc_q;
  assign ADC_En       = adc_en_q;
  assign Sample       = sample_q;
  assign Sample_Valid = sample_valid_q;
  assign Period       = period_q;
  assign Period_Valid = period_valid_q;
  assign Timeout      = timeout_q;

endmodule

// File: tb/tb_adc_freq_front.sv
// Directed bench for adc_freq_front: sample clock, capture, period measurement, reset and timeout.
module tb_adc_freq_front;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] div;
  logic [23:0] gate;
  logic [7:0]  adc_data;
  logic [7:0]  adc_data_to;
  logic [11:0] gate_to = '0;

  logic        clk_adc, adc_en, sample_valid, period_valid, timeout;
  logic [7:0]  sample;
  logic [23:0] period;
  logic        clk_adc_to, adc_en_to, sample_valid_to, period_valid_to, timeout_to;
  logic [7:0]  sample_to;
  logic [11:0] period_to;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit wave_on = 1'b0;
  int half    = 1;
  int wave_cnt = 0;

  always #5 clk = ~clk;

  adc_freq_front u_dut (
    .clk_100MHz   (clk),
    .Rst          (rst_n),
    .Div          (div),
    .Gate_Cycles  (gate),
    .ADC_Data     (adc_data),
    .clk_ADC      (clk_adc),
    .ADC_En       (adc_en),
    .Sample       (sample),
    .Sample_Valid (sample_valid),
    .Period       (period),
    .Period_Valid (period_valid),
    .Timeout      (timeout)
  );

  adc_freq_front #(
    .CNT_W(12)
  ) u_dut_to (
    .clk_100MHz   (clk),
    .Rst          (rst_n),
    .Div          (div),
    .Gate_Cycles  (gate_to),
    .ADC_Data     (adc_data_to),
    .clk_ADC      (clk_adc_to),
    .ADC_En       (adc_en_to),
    .Sample       (sample_to),
    .Sample_Valid (sample_valid_to),
    .Period       (period_to),
    .Period_Valid (period_valid_to),
    .Timeout      (timeout_to)
  );

  // Advance to the next falling edge and drive the waveforms for the following rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (wave_on) begin
      adc_data = (((wave_cnt / half) % 2) == 1) ? 8'hFF : 8'h00;
      wave_cnt++;
    end
    adc_data_to = (((cyc / 30) % 2) == 1) ? 8'd135 : 8'd121;
  endtask

  task automatic do_reset(input logic [15:0] d, input logic [23:0] g, input int h, input bit w);
    rst_n    = 1'b0;
    div      = d;
    gate     = g;
    half     = h;
    wave_on  = w;
    adc_data = 8'h00;
    repeat (3) tick();
    wave_cnt = 0;
    adc_data = 8'h00;
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    div = 16'd3; gate = 24'd0; wave_on = 1'b0; adc_data = 8'hA5;
    repeat (2) tick();
    n_cmp++; if (clk_adc !== 1'b0) begin n_fail++; $display("FAIL reset_clk_ADC got %0b want 0", clk_adc); end
    n_cmp++; if (adc_en !== 1'b0) begin n_fail++; $display("FAIL reset_ADC_En got %0b want 0", adc_en); end
    n_cmp++; if (sample !== 8'h00) begin n_fail++; $display("FAIL reset_Sample got %0h want 0", sample); end
    n_cmp++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_Sample_Valid got %0b want 0", sample_valid); end
    n_cmp++; if (period !== 24'd0) begin n_fail++; $display("FAIL reset_Period got %0d want 0", period); end
    n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL reset_Period_Valid got %0b want 0", period_valid); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_Timeout got %0b want 0", timeout); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (adc_en !== 1'b1) begin n_fail++; $display("FAIL adc_en_after_reset got %0b want 1", adc_en); end
  endtask

  task automatic test_div50();
    int rise, fall, sv_seen;
    logic [7:0] drv;
    do_reset(16'd50, 24'd0, 1, 1'b0);
    rise = -1; fall = -1; sv_seen = 0; drv = 8'h00;
    for (int k = 1; k <= 360; k++) begin
      tick();
      if (rise < 0 && clk_adc === 1'b1) rise = k;
      if (rise >= 0 && fall < 0 && clk_adc === 1'b0) fall = k;
      if (sample_valid === 1'b1) begin
        n_cmp++; if (sample !== drv) begin n_fail++; $display("FAIL div50_sample got %0h want %0h", sample, drv); end
        n_cmp++; if (k != 100 * (sv_seen + 1)) begin n_fail++; $display("FAIL div50_sv_cycle got %0d want %0d", k, 100 * (sv_seen + 1)); end
        sv_seen++;
      end
      drv = 8'(k * 37 + 11);
      adc_data = drv;
    end
    n_cmp++; if (rise != 50) begin n_fail++; $display("FAIL div50_first_rise got %0d want 50", rise); end
    n_cmp++; if (fall != 100) begin n_fail++; $display("FAIL div50_first_fall got %0d want 100", fall); end
    n_cmp++; if (sv_seen != 3) begin n_fail++; $display("FAIL div50_sv_count got %0d want 3", sv_seen); end
  endtask

  task automatic test_div_change();
    logic exp;
    do_reset(16'd0, 24'd0, 1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = ((k % 2) == 1);
      n_cmp++; if (clk_adc !== exp) begin n_fail++; $display("FAIL div0_toggle k=%0d got %0b want %0b", k, clk_adc, exp); end
    end
    do_reset(16'd4, 24'd0, 1, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp = (k >= 4 && k < 8) || (k >= 16);
      n_cmp++; if (clk_adc !== exp) begin n_fail++; $display("FAIL div4to8 k=%0d got %0b want %0b", k, clk_adc, exp); end
      if (k == 5) div = 16'd8;
    end
  endtask

  task automatic test_back_to_back();
    int got;
    logic prev_pv;
    do_reset(16'd5, 24'd3000, 500, 1'b1);
    got = 0; prev_pv = 1'b0;
    for (int k = 1; k <= 12000 && got < 2; k++) begin
      tick();
      if (period_valid === 1'b1) begin
        got++;
        n_cmp++; if (period !== 24'd1000) begin n_fail++; $display("FAIL b2b_period%0d got %0d want 1000", got, period); end
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout%0d got %0b want 0", got, timeout); end
        n_cmp++; if (prev_pv !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_width got %0b want 0", prev_pv); end
      end
      prev_pv = period_valid;
    end
    n_cmp++; if (got != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", got); end
  endtask

  task automatic test_gate_zero();
    int cross_k, got;
    logic [7:0] prev_s;
    do_reset(16'd10, 24'd0, 1000, 1'b1);
    cross_k = 0; got = 0; prev_s = 8'h00;
    for (int k = 1; k <= 6000 && got == 0; k++) begin
      tick();
      if (sample_valid === 1'b1) begin
        if (sample === 8'hFF && prev_s === 8'h00) cross_k = k;
        prev_s = sample;
      end
      if (period_valid === 1'b1) begin
        got = 1;
        n_cmp++; if (period !== 24'd2000) begin n_fail++; $display("FAIL g0_period got %0d want 2000", period); end
        n_cmp++; if (k - cross_k != 27) begin n_fail++; $display("FAIL g0_latency got %0d want 27", k - cross_k); end
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL g0_timeout got %0b want 0", timeout); end
      end
    end
    n_cmp++; if (got != 1) begin n_fail++; $display("FAIL g0_seen got %0d want 1", got); end
  endtask

  task automatic test_reset_in_div();
    int ncross, hit_k, pv_cnt, got;
    logic [7:0] prev_s;
    do_reset(16'd10, 24'd0, 1000, 1'b1);
    ncross = 0; hit_k = -1; prev_s = 8'h00; pv_cnt = 0;
    for (int k = 1; k <= 5000 && !(hit_k > 0 && k > hit_k + 5); k++) begin
      tick();
      if (sample_valid === 1'b1) begin
        if (sample === 8'hFF && prev_s === 8'h00) begin
          ncross++;
          if (ncross == 2) hit_k = k;
        end
        prev_s = sample;
      end
      if (period_valid === 1'b1) pv_cnt++;
    end
    n_cmp++; if (hit_k < 0) begin n_fail++; $display("FAIL rdiv_crossing got none want 2"); end
    n_cmp++; if (pv_cnt != 0) begin n_fail++; $display("FAIL rdiv_early_pv got %0d want 0", pv_cnt); end
    wave_on = 1'b0; adc_data = 8'h00;
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({clk_adc, adc_en, sample_valid, period_valid, timeout} !== 5'b0) begin n_fail++; $display("FAIL rdiv_flags got %05b want 00000", {clk_adc, adc_en, sample_valid, period_valid, timeout}); end
    n_cmp++; if (sample !== 8'h00) begin n_fail++; $display("FAIL rdiv_sample got %0h want 0", sample); end
    n_cmp++; if (period !== 24'd0) begin n_fail++; $display("FAIL rdiv_period got %0d want 0", period); end
    wave_cnt = 0; wave_on = 1'b1; rst_n = 1'b1;
    pv_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (period_valid === 1'b1) pv_cnt++;
    end
    n_cmp++; if (pv_cnt != 0) begin n_fail++; $display("FAIL rdiv_no_pv got %0d want 0", pv_cnt); end
    got = 0;
    for (int k = 1; k <= 6000 && got == 0; k++) begin
      tick();
      if (period_valid === 1'b1) begin
        got = 1;
        n_cmp++; if (period !== 24'd2000) begin n_fail++; $display("FAIL rdiv_fresh_period got %0d want 2000", period); end
      end
    end
    n_cmp++; if (got != 1) begin n_fail++; $display("FAIL rdiv_fresh_seen got %0d want 1", got); end
  endtask

  task automatic test_timeout();
    int pv_cnt;
    do_reset(16'd10, 24'd0, 1, 1'b0);
    pv_cnt = 0;
    for (int k = 1; k <= 4300; k++) begin
      tick();
      if (period_valid_to === 1'b1) pv_cnt++;
      if (k == 4000) begin
        n_cmp++; if (timeout_to !== 1'b0) begin n_fail++; $display("FAIL to_early got %0b want 0", timeout_to); end
      end
    end
    n_cmp++; if (timeout_to !== 1'b1) begin n_fail++; $display("FAIL to_set got %0b want 1", timeout_to); end
    n_cmp++; if (period_to !== 12'd0) begin n_fail++; $display("FAIL to_period got %0d want 0", period_to); end
    n_cmp++; if (pv_cnt != 0) begin n_fail++; $display("FAIL to_no_pv got %0d want 0", pv_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; div = 16'd1; gate = 24'd0; adc_data = 8'h00; adc_data_to = 8'd128;
    test_reset();
    test_div50();
    test_div_change();
    test_back_to_back();
    test_gate_zero();
    test_reset_in_div();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
